// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: compares programmable 24-hour alarm slots against the
// running clock on each minute tick and sequences ring / snooze / dismiss / timeout.
module alarm_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_W         = 2,
  parameter int RING_MINUTES   = 1,
  parameter int SNOOZE_MINUTES = 10,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              min_tick,
  input  logic [4:0]        cur_hrs,
  input  logic [5:0]        cur_min,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [4:0]        wr_hrs,
  input  logic [5:0]        wr_min,
  input  logic              wr_enable,
  input  logic              snooze,
  input  logic              dismiss,
  output logic              alarm,
  output logic [SLOT_W-1:0] active_slot,
  output logic [2:0]        snoozes_left,
  output logic              missed,
  output logic              wr_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_e;

  localparam logic [3:0] RING_LOAD = 4'(RING_MINUTES);
  localparam logic [5:0] SNZ_LOAD  = 6'(SNOOZE_MINUTES);
  localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

  logic [NUM_SLOTS-1:0] en_q, en_d;
  logic [4:0]           hrs_q [NUM_SLOTS];
  logic [4:0]           hrs_d [NUM_SLOTS];
  logic [5:0]           min_q [NUM_SLOTS];
  logic [5:0]           min_d [NUM_SLOTS];

  state_e              state_q, state_d;
  logic [3:0]          ring_cnt_q, ring_cnt_d;
  logic [5:0]          snz_cnt_q, snz_cnt_d;
  logic [SLOT_W-1:0]   active_slot_q, active_slot_d;
  logic [2:0]          snoozes_left_q, snoozes_left_d;
  logic                alarm_q, alarm_d;
  logic                missed_q, missed_d;
  logic                wr_err_q, wr_err_d;

  logic                wr_valid_s;
  logic                match_s;
  logic [SLOT_W-1:0]   winner_s;
  logic                kill_s;

  assign wr_valid_s = wr_en && (wr_hrs <= 5'd23) && (wr_min <= 6'd59);
  // Disabling the slot that owns the event cancels it outright (never counts as missed).
  assign kill_s     = wr_valid_s && !wr_enable && (wr_slot == active_slot_q) &&
                      (state_q != ST_IDLE);

  // Lowest-index match against the pre-write slot contents.
  always_comb begin
    match_s  = 1'b0;
    winner_s = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (min_tick && en_q[i] && (hrs_q[i] == cur_hrs) && (min_q[i] == cur_min)) begin
        match_s  = 1'b1;
        winner_s = SLOT_W'(i);
      end else begin
        match_s  = match_s;
      end
    end
  end

  // Slot register file update.
  always_comb begin
    en_d     = en_q;
    hrs_d    = hrs_q;
    min_d    = min_q;
    wr_err_d = wr_en && !wr_valid_s;
    if (wr_valid_s) begin
      en_d[wr_slot]  = wr_enable;
      hrs_d[wr_slot] = wr_hrs;
      min_d[wr_slot] = wr_min;
    end else begin
      en_d = en_q;
    end
  end

  // Event sequencing: ring, snooze, dismiss, timeout, preemption.
  always_comb begin
    state_d        = state_q;
    ring_cnt_d     = ring_cnt_q;
    snz_cnt_d      = snz_cnt_q;
    active_slot_d  = active_slot_q;
    snoozes_left_d = snoozes_left_q;
    missed_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (match_s) begin
          state_d        = ST_RINGING;
          active_slot_d  = winner_s;
          ring_cnt_d     = RING_LOAD;
          snoozes_left_d = SNZ_MAX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RINGING: begin
        if (kill_s || dismiss) begin
          state_d = ST_IDLE;
        end else if (snooze && (snoozes_left_q != 3'd0)) begin
          state_d        = ST_SNOOZED;
          snz_cnt_d      = SNZ_LOAD;
          snoozes_left_d = snoozes_left_q - 3'd1;
        end else if (min_tick) begin
          if (ring_cnt_q <= 4'd1) begin
            state_d    = ST_IDLE;
            ring_cnt_d = 4'd0;
            missed_d   = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q - 4'd1;
          end
        end else begin
          state_d = ST_RINGING;
        end
      end
      ST_SNOOZED: begin
        if (kill_s || dismiss) begin
          state_d = ST_IDLE;
        end else if (match_s) begin
          state_d        = ST_RINGING;
          active_slot_d  = winner_s;
          ring_cnt_d     = RING_LOAD;
          snoozes_left_d = SNZ_MAX;
        end else if (min_tick) begin
          if (snz_cnt_q <= 6'd1) begin
            state_d    = ST_RINGING;
            snz_cnt_d  = 6'd0;
            ring_cnt_d = RING_LOAD;
          end else begin
            snz_cnt_d = snz_cnt_q - 6'd1;
          end
        end else begin
          state_d = ST_SNOOZED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    alarm_d = (state_d == ST_RINGING);
  end

  // State, slot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q           <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        hrs_q[i] <= 5'd0;
        min_q[i] <= 6'd0;
      end
      state_q        <= ST_IDLE;
      ring_cnt_q     <= 4'd0;
      snz_cnt_q      <= 6'd0;
      active_slot_q  <= '0;
      snoozes_left_q <= 3'd0;
      alarm_q        <= 1'b0;
      missed_q       <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      en_q           <= en_d;
      hrs_q          <= hrs_d;
      min_q          <= min_d;
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snz_cnt_q      <= snz_cnt_d;
      active_slot_q  <= active_slot_d;
      snoozes_left_q <= snoozes_left_d;
      alarm_q        <= alarm_d;
      missed_q       <= missed_d;
      wr_err_q       <= wr_err_d;
    end
  end

  assign alarm        = alarm_q;
  assign active_slot  = active_slot_q;
  assign snoozes_left = snoozes_left_q;
  assign missed       = missed_q;
  assign wr_err       = wr_err_q;

endmodule
